rot_arbiter: RTL and testbench

ROT_ARBITER -- requirements
Module: rot_arbiter

---
 rtl/rot_pkg.sv | 13 +
 rtl/rotr8.sv | 24 ++
 rtl/rot_arbiter.sv | 108 ++++++++++
 tb/tb_rot_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared constants and FSM state type for the rotate arbiter.
// Holds requester count, operand/amount widths and the result-register state enum.
package rot_pkg;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int IDW  = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/rotr8.sv
// Combinational 8-bit rotate-right by a 3-bit amount.
module rotr8
  import rot_pkg::*;
(
  input  logic [DW-1:0] i_data,
  input  logic [AW-1:0] i_amt,
  output logic [DW-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_amt)
      3'd1:    o_data = {i_data[0],   i_data[7:1]};
      3'd2:    o_data = {i_data[1:0], i_data[7:2]};
      3'd3:    o_data = {i_data[2:0], i_data[7:3]};
      3'd4:    o_data = {i_data[3:0], i_data[7:4]};
      3'd5:    o_data = {i_data[4:0], i_data[7:5]};
      3'd6:    o_data = {i_data[5:0], i_data[7:6]};
      3'd7:    o_data = {i_data[6:0], i_data[7]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/rot_arbiter.sv
// Round-robin arbiter feeding a single-entry rotate result register.
// state    | meaning
// ST_EMPTY | no result held, res_valid=0, grants accepted freely
// ST_FULL  | result held, res_valid=1, grant only when it is consumed
module rot_arbiter #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*rot_pkg::DW-1:0]   req_data,
  input  logic [NREQ*rot_pkg::AW-1:0]   req_amt,
  output logic [NREQ-1:0]               gnt,
  output logic                          res_valid,
  output logic [rot_pkg::DW-1:0]        res_data,
  output logic [rot_pkg::IDW-1:0]       res_id,
  input  logic                          res_ready,
  output logic [CNTW-1:0]               op_count
);
  import rot_pkg::*;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [DW-1:0]   r_data;
  logic [CNTW-1:0] r_op_count;

  logic              w_can_accept;
  logic              w_any;
  logic              w_consume;
  logic [IDW-1:0]    w_off;
  logic [IDW-1:0]    w_idx;
  logic [2*NREQ-1:0] w_req_dbl;
  logic [NREQ-1:0]   w_req_rot;
  logic [DW-1:0]     w_sel_data;
  logic [AW-1:0]     w_sel_amt;
  logic [DW-1:0]     w_rot;

  assign w_can_accept = (r_state == ST_EMPTY) | res_ready;
  assign w_consume    = (r_state == ST_FULL) & res_ready;

  // Rotating the request vector by ptr turns the round-robin search into a plain priority pick.
  assign w_req_dbl = {req, req};
  assign w_req_rot = w_req_dbl[r_ptr +: NREQ];

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) w_off = IDW'(k);
    end
  end

  assign w_any = (|w_req_rot) & w_can_accept & ~reset;
  assign w_idx = r_ptr + w_off;
  assign gnt   = w_any ? (NREQ'(1) << w_idx) : '0;

  always_comb begin
    w_sel_data = '0;
    w_sel_amt  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == IDW'(i)) begin
        w_sel_data = req_data[DW*i +: DW];
        w_sel_amt  = req_amt[AW*i +: AW];
      end
    end
  end

  rotr8 u_rotr8 (
    .i_data (w_sel_data),
    .i_amt  (w_sel_amt),
    .o_data (w_rot)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_any) w_state_nxt = ST_FULL;
      ST_FULL:  if (w_consume && !w_any) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_ptr      <= '0;
      r_data     <= '0;
      r_id       <= '0;
      r_op_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_consume) r_op_count <= r_op_count + CNTW'(1);
      if (w_any) begin
        r_data <= w_rot;
        r_id   <= w_idx;
        r_ptr  <= w_idx + IDW'(1);
      end
    end
  end

  assign res_valid = (r_state == ST_FULL);
  assign res_data  = r_data;
  assign res_id    = r_id;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_rot_arbiter.sv
// Randomized and directed bench for rot_arbiter against an in-bench behavioural model.
module tb_rot_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [11:0] req_amt;
  logic [3:0]  gnt;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [1:0]  res_id;
  logic        res_ready;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;

  // Model of the observable state
  int          m_ptr;
  bit          m_valid;
  logic [7:0]  m_data;
  logic [1:0]  m_id;
  logic [15:0] m_cnt;

  rot_arbiter #(.NREQ(4), .CNTW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_rot(input logic [7:0] d, input int a);
    int v;
    v = int'(d);
    return 8'(((v >> a) | (v << (8 - a))) & 255);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every output with the model, then advance the model.
  task automatic step(input logic [3:0] r, input logic rdy, input logic rst,
                      input logic [31:0] d, input logic [11:0] a);
    int gi;
    logic [3:0] exp_g;
    @(negedge clk);
    req = r; res_ready = rdy; reset = rst; req_data = d; req_amt = a;
    #1;
    gi = -1;
    if (!rst && (!m_valid || rdy)) begin
      for (int k = 0; k < 4; k++) begin
        if (gi < 0 && r[(m_ptr + k) % 4]) gi = (m_ptr + k) % 4;
      end
    end
    exp_g = (gi >= 0) ? 4'(1 << gi) : 4'b0000;
    check("gnt",       gnt,       exp_g);
    check("res_valid", res_valid, m_valid);
    check("res_data",  res_data,  m_data);
    check("res_id",    res_id,    m_id);
    check("op_count",  op_count,  m_cnt);
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_data = 8'h00; m_id = 2'd0; m_cnt = 16'd0;
    end else begin
      if (m_valid && rdy) begin
        m_cnt   = m_cnt + 16'd1;
        m_valid = 0;
      end
      if (gi >= 0) begin
        m_data  = ref_rot(d[8*gi +: 8], int'(a[3*gi +: 3]));
        m_id    = 2'(gi);
        m_valid = 1;
        m_ptr   = (gi + 1) % 4;
      end
    end
  endtask

  initial begin
    logic [7:0] held_data;
    logic [1:0] held_id;
    m_ptr = 0; m_valid = 0; m_data = 8'h00; m_id = 2'd0; m_cnt = 16'd0;
    reset = 1'b1; req = '0; req_data = '0; req_amt = '0; res_ready = 1'b0;

    // Reset with requests pending: no grant, everything cleared
    step(4'b1111, 1'b1, 1'b1, 32'h0, 12'h0);
    check("lit_gnt_in_reset", gnt, 4'b0000);
    step(4'b0000, 1'b1, 1'b1, 32'h0, 12'h0);
    check("lit_reset_valid", res_valid, 1'b0);
    check("lit_reset_count", op_count, 16'd0);

    // Single request, A5 rotated right by 1
    step(4'b0001, 1'b1, 1'b0, 32'h0000_00A5, 12'h001);
    check("lit_single_gnt", gnt, 4'b0001);
    step(4'b0000, 1'b1, 1'b0, 32'h0, 12'h0);
    check("lit_single_valid", res_valid, 1'b1);
    check("lit_single_data", res_data, 8'hD2);
    check("lit_single_id", res_id, 2'd0);
    step(4'b0000, 1'b1, 1'b0, 32'h0, 12'h0);
    check("lit_single_count", op_count, 16'd1);

    // Rotate amounts 4, 7, 0
    step(4'b0001, 1'b1, 1'b0, 32'h0000_003C, 12'h004);
    step(4'b0001, 1'b1, 1'b0, 32'h0000_0081, 12'h007);
    check("lit_rot4", res_data, 8'hC3);
    step(4'b0001, 1'b1, 1'b0, 32'h0000_005A, 12'h000);
    check("lit_rot7", res_data, 8'h03);
    step(4'b0000, 1'b1, 1'b0, 32'h0, 12'h0);
    check("lit_rot0", res_data, 8'h5A);

    // All requesting from ptr=0: strict rotation, one result per cycle
    step(4'b0000, 1'b1, 1'b1, 32'h0, 12'h0);
    step(4'b1111, 1'b1, 1'b0, 32'h1122_3344, 12'h0);
    check("lit_rr0", gnt, 4'b0001);
    step(4'b1111, 1'b1, 1'b0, 32'h1122_3344, 12'h0);
    check("lit_rr1", gnt, 4'b0010);
    check("lit_rr_valid1", res_valid, 1'b1);
    step(4'b1111, 1'b1, 1'b0, 32'h1122_3344, 12'h0);
    check("lit_rr2", gnt, 4'b0100);
    check("lit_rr_valid2", res_valid, 1'b1);
    step(4'b1111, 1'b1, 1'b0, 32'h1122_3344, 12'h0);
    check("lit_rr3", gnt, 4'b1000);
    check("lit_rr_valid3", res_valid, 1'b1);
    step(4'b1111, 1'b1, 1'b0, 32'h1122_3344, 12'h0);
    check("lit_rr4", gnt, 4'b0001);
    check("lit_rr_valid4", res_valid, 1'b1);

    // Backpressure while FULL (ptr now 1): no grant, output held
    held_data = m_data;
    held_id   = m_id;
    for (int i = 0; i < 3; i++) begin
      step(4'b0110, 1'b0, 1'b0, 32'hDEAD_BEEF, 12'h5A5);
      check("lit_bp_gnt", gnt, 4'b0000);
      check("lit_bp_data", res_data, held_data);
      check("lit_bp_id", res_id, held_id);
    end
    step(4'b0110, 1'b1, 1'b0, 32'hDEAD_BEEF, 12'h5A5);
    check("lit_bp_release", gnt, 4'b0010);

    // Reset while FULL discards the result and rewinds ptr
    step(4'b0000, 1'b0, 1'b1, 32'h0, 12'h0);
    step(4'b1000, 1'b1, 1'b0, 32'h8000_0000, 12'h0);
    check("lit_rst_full_valid", res_valid, 1'b0);
    check("lit_rst_full_count", op_count, 16'd0);
    check("lit_rst_full_gnt", gnt, 4'b1000);
    step(4'b0000, 1'b1, 1'b1, 32'h0, 12'h0);
    step(4'b1111, 1'b1, 1'b0, 32'h0, 12'h0);
    check("lit_rst_ptr", gnt, 4'b0001);

    // Randomized traffic with occasional resets and request withdrawal
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 99) == 0), $urandom, 12'($urandom));
    end

    // Counter wrap: one grant, then 65536 back-to-back consumes
    step(4'b0000, 1'b1, 1'b1, 32'h0, 12'h0);
    for (int i = 0; i < 65537; i++) begin
      step(4'b1111, 1'b1, 1'b0, $urandom, 12'($urandom));
    end
    check("lit_wrap_max", op_count, 16'hFFFF);
    step(4'b0000, 1'b1, 1'b0, 32'h0, 12'h0);
    check("lit_wrap_zero", op_count, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
